regfile_port_ctrl: RTL and testbench
====================================

// Module: regfile_port_ctrl
// PURPOSE
//  Front-end controller for the 32x32 dual-port block-RAM register file. Drives both RAM ports.
//  Arbitrates core read requests (rs1 on port A, rs2 on port B) against write-back (port A).
//  Enforces the x0 == 0 rule and holds read data stable between accepted reads.
//  Optionally zero-fills the RAM after reset. Sits between decode/write-back and the RAM primitive.
// PARAMETERS
//  ADDR_W    5   register address width (RAM depth = 2**ADDR_W)
//  DATA_W    32  register data width
//  ZERO_REG  1   1: address 0 reads as 0 and ignores writes; 0: address 0 is an ordinary entry
// PORTS
//  clk         in   1       single clock; both RAM ports use this clock
//  rst_n       in   1       asynchronous active-low reset
//  rd_req      in   1       read request (rs1_addr and rs2_addr are valid)
//  rs1_addr    in   ADDR_W  source register 1
//  rs2_addr    in   ADDR_W  source register 2
//  rd_ready    out  1       a read is accepted when rd_req && rd_ready
//  rdata_valid out  1       one-cycle pulse; read data valid for the accepted read
//  rs1_data    out  DATA_W  rs1 value; held until the next rdata_valid
//  rs2_data    out  DATA_W  rs2 value; held until the next rdata_valid
//  wb_en       in   1       write-back strobe
//  wb_addr     in   ADDR_W  write-back destination
//  wb_data     in   DATA_W  write-back value
//  init_done   out  1       high once the RAM is usable
//  ram_cea     out  1       RAM port A clock enable
//  ram_wrea    out  1       RAM port A write enable
//  ram_ada     out  ADDR_W  RAM port A address
//  ram_dina    out  DATA_W  RAM port A write data
//  ram_douta   in   DATA_W  RAM port A read data (1-cycle latency, bypass output mode)
//  ram_ceb     out  1       RAM port B clock enable (port B is read-only: its WRE and DIN are tied low by the integrating top level)
//  ram_adb     out  ADDR_W  RAM port B address
//  ram_doutb   in   DATA_W  RAM port B read data (1-cycle latency)
// BEHAVIOUR
//  States: INIT (present only with the macro) and RUN. Reset enters INIT if it is compiled in, otherwise RUN.
//  Reset values: rd_ready=0, rdata_valid=0, rs1_data=rs2_data=0, ram_cea=ram_wrea=ram_ceb=0, ram_ada=ram_adb=0, ram_dina=0.
//    init_done=0 with the macro; 1 without it.
//  Write qualification: wb_eff = wb_en && !(ZERO_REG && wb_addr==0) && state==RUN.
//    In INIT, wb_en is ignored. Writes to x0 never reach the RAM and never stall.
//  rd_ready (combinational) = state==RUN && !wb_eff. Write-back always has priority over a read on port A.
//  Write cycle: ram_cea=1, ram_wrea=1, ram_ada=wb_addr, ram_dina=wb_data. The RAM is updated at that edge.
//  Accepted read in cycle N:
//    ram_cea=ram_ceb=1, ram_wrea=0, ram_ada=rs1_addr, ram_adb=rs2_addr.
//    Registers the flags z1=(ZERO_REG && rs1_addr==0) and z2=(ZERO_REG && rs2_addr==0).
//  Cycle N+1: rdata_valid=1; rs1_data = z1 ? 0 : ram_douta; rs2_data = z2 ? 0 : ram_doutb.
//    Both values are also captured into hold registers on that edge.
//  Other cycles: rs*_data come from the hold registers. Port A write-through activity never disturbs them.
//  Read latency is 1 cycle. Back-to-back reads give one result per cycle.
//  Read/write ordering:
//    A write in cycle N followed by a read of the same address in cycle N+1 returns the new value.
//    An accepted read in cycle N followed by a write in cycle N+1 returns the old value.
//  Idle cycle (no write, no accepted read): ram_cea=ram_ceb=0, so RAM outputs are held.
//  Reset asserted mid-operation: immediate return to reset values and entry state. Any pending rdata_valid is dropped.
// CONFIGURATION
//  REGFILE_CLEAR_EN defined:
//    After rst_n deasserts, INIT writes zero to addresses 0..2**ADDR_W-1 via port A, one per cycle.
//    During INIT: ram_wrea=ram_cea=1 and ram_ada = 5-bit counter.
//    After the final write: counter wrap -> RUN; init_done=1 on the next cycle.
//    With ADDR_W=5, init_done rises 32 cycles after the first clock edge following reset release.
//  REGFILE_CLEAR_EN undefined:
//    No INIT state and no counter. RUN directly from reset; init_done is constant 1.
//    RAM contents are undefined until written (x0 still reads 0 when ZERO_REG=1).
// TESTING
//  T1 (CLEAR_EN) release rst_n -> 32 cycles of ram_wrea=1, ram_ada 0..31, ram_dina=0, rd_ready=0, then init_done=1 and rd_ready=1.
//  T2 wb x5=0xDEADBEEF; next cycle rd_req rs1=5 rs2=0 -> following cycle rdata_valid=1, rs1_data=0xDEADBEEF, rs2_data=0.
//  T3 wb_en x3=0x12345678 with rd_req rs1=3 in the same cycle -> rd_ready=0; read accepted the next cycle and returns 0x12345678.
//  T4 wb_en x0=0xFFFFFFFF with rd_req -> rd_ready=1, ram_wrea=0; a later read of x0 returns 0.
//  T5 after a valid read with rs1_data=0xA5A5A5A5, write x7=0x1 for 3 cycles -> rs1_data stays 0xA5A5A5A5 and rdata_valid=0.
//  T6 (CLEAR_EN) pull rst_n low at INIT count 10 for 2 cycles -> outputs return to reset values; a full 32-cycle INIT is repeated.

Source files
------------

// File: rtl/regfile_port_ctrl.sv
// regfile_port_ctrl: port arbiter for a 2**ADDR_W x DATA_W dual-port BRAM regfile.
// Define REGFILE_CLEAR_EN to zero-fill the RAM through port A after reset.
module regfile_port_ctrl #(
   parameter int ADDR_W   = 5,
   parameter int DATA_W   = 32,
   parameter bit ZERO_REG = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rs1_addr,
   input  logic [ADDR_W-1:0] rs2_addr,
   output logic              rd_ready,
   output logic              rdata_valid,
   output logic [DATA_W-1:0] rs1_data,
   output logic [DATA_W-1:0] rs2_data,
   input  logic              wb_en,
   input  logic [ADDR_W-1:0] wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   output logic              init_done,
   output logic              ram_cea,
   output logic              ram_wrea,
   output logic [ADDR_W-1:0] ram_ada,
   output logic [DATA_W-1:0] ram_dina,
   input  logic [DATA_W-1:0] ram_douta,
   output logic              ram_ceb,
   output logic [ADDR_W-1:0] ram_adb,
   input  logic [DATA_W-1:0] ram_doutb
);

   logic              w_run;
   logic              w_init_wr;
   logic [ADDR_W-1:0] w_init_ad;
   logic              w_wb_eff;
   logic              w_rd_acc;
   logic [DATA_W-1:0] w_d1;
   logic [DATA_W-1:0] w_d2;

   logic              r_rv;
   logic              r_z1;
   logic              r_z2;
   logic [DATA_W-1:0] r_h1;
   logic [DATA_W-1:0] r_h2;

`ifdef REGFILE_CLEAR_EN
   typedef enum logic {S_INIT, S_RUN} state_t;

   state_t            r_state;
   logic [ADDR_W-1:0] r_cnt;
   logic              r_init_done;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_INIT;
         r_cnt       <= '0;
         r_init_done <= 1'b0;
      end else begin
         if (r_state == S_INIT) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == '1)
               r_state <= S_RUN;
         end
         r_init_done <= (r_state == S_RUN);
      end
   end

   assign w_run     = rst_n && (r_state == S_RUN);
   assign w_init_wr = rst_n && (r_state == S_INIT);
   assign w_init_ad = r_cnt;
   assign init_done = r_init_done;
`else
   assign w_run     = rst_n;
   assign w_init_wr = 1'b0;
   assign w_init_ad = '0;
   assign init_done = 1'b1;
`endif

   // x0 writes are dropped here so they never steal port A from a read
   assign w_wb_eff = w_run && wb_en && !(ZERO_REG && (wb_addr == '0));
   assign rd_ready = w_run && !w_wb_eff;
   assign w_rd_acc = rd_req && rd_ready;

   always_comb begin
      ram_cea  = 1'b0;
      ram_wrea = 1'b0;
      ram_ada  = '0;
      ram_dina = '0;
      ram_ceb  = 1'b0;
      ram_adb  = '0;
      unique case (1'b1)
         w_init_wr: begin
            ram_cea  = 1'b1;
            ram_wrea = 1'b1;
            ram_ada  = w_init_ad;
         end
         w_wb_eff: begin
            ram_cea  = 1'b1;
            ram_wrea = 1'b1;
            ram_ada  = wb_addr;
            ram_dina = wb_data;
         end
         w_rd_acc: begin
            ram_cea = 1'b1;
            ram_ceb = 1'b1;
            ram_ada = rs1_addr;
            ram_adb = rs2_addr;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rv <= 1'b0;
         r_z1 <= 1'b0;
         r_z2 <= 1'b0;
         r_h1 <= '0;
         r_h2 <= '0;
      end else begin
         r_rv <= w_rd_acc;
         if (w_rd_acc) begin
            r_z1 <= ZERO_REG && (rs1_addr == '0);
            r_z2 <= ZERO_REG && (rs2_addr == '0);
         end
         if (r_rv) begin
            r_h1 <= w_d1;
            r_h2 <= w_d2;
         end
      end
   end

   // RAM outputs are only trusted in the cycle right after the read
   assign w_d1        = r_z1 ? '0 : ram_douta;
   assign w_d2        = r_z2 ? '0 : ram_doutb;
   assign rdata_valid = r_rv;
   assign rs1_data    = r_rv ? w_d1 : r_h1;
   assign rs2_data    = r_rv ? w_d2 : r_h2;

endmodule

// File: tb/tb_regfile_port_ctrl.sv
// tb_regfile_port_ctrl: directed bench with a BRAM model and a register-file model.
// Build with REGFILE_CLEAR_EN defined to exercise the zero-fill sequence.
module tb_regfile_port_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        rd_req = 1'b0;
   logic [4:0]  rs1_addr = '0;
   logic [4:0]  rs2_addr = '0;
   logic        rd_ready;
   logic        rdata_valid;
   logic [31:0] rs1_data;
   logic [31:0] rs2_data;
   logic        wb_en = 1'b0;
   logic [4:0]  wb_addr = '0;
   logic [31:0] wb_data = '0;
   logic        init_done;
   logic        ram_cea;
   logic        ram_wrea;
   logic [4:0]  ram_ada;
   logic [31:0] ram_dina;
   logic [31:0] ram_douta;
   logic        ram_ceb;
   logic [4:0]  ram_adb;
   logic [31:0] ram_doutb;

   int n_vec = 0;
   int n_bad = 0;
   bit tb_fill = 1'b1;

   always #5 clk = ~clk;

   regfile_port_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .rd_req(rd_req), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
      .rd_ready(rd_ready), .rdata_valid(rdata_valid),
      .rs1_data(rs1_data), .rs2_data(rs2_data),
      .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .init_done(init_done),
      .ram_cea(ram_cea), .ram_wrea(ram_wrea), .ram_ada(ram_ada),
      .ram_dina(ram_dina), .ram_douta(ram_douta),
      .ram_ceb(ram_ceb), .ram_adb(ram_adb), .ram_doutb(ram_doutb)
   );

   // dual-port BRAM, port A write-through, preloaded with junk
   logic [31:0] mem [32];
   always @(posedge clk) begin
      if (tb_fill) begin
         for (int i = 0; i < 32; i++) mem[i] <= 32'hBAD0_0000 + i;
      end else begin
         if (ram_cea) begin
            if (ram_wrea) begin
               mem[ram_ada] <= ram_dina;
               ram_douta    <= ram_dina;
            end else begin
               ram_douta <= mem[ram_ada];
            end
         end
         if (ram_ceb) ram_doutb <= mem[ram_adb];
      end
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // architectural model: register values, INIT progress, read results
   int          m_cnt;
   bit          m_run, m_idone, m_pend;
   logic [31:0] m_reg [32];
   logic [31:0] m_e1, m_e2, m_h1, m_h2;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
`ifdef REGFILE_CLEAR_EN
         m_run   = 1'b0;
         m_idone = 1'b0;
`else
         m_run   = 1'b1;
         m_idone = 1'b1;
`endif
         m_cnt  = 0;
         m_pend = 1'b0;
         m_h1   = '0;
         m_h2   = '0;
      end else begin
         if (m_run) m_idone = 1'b1;
         if (m_pend) begin
            m_h1   = m_e1;
            m_h2   = m_e2;
            m_pend = 1'b0;
         end
         if (!m_run) begin
            m_reg[m_cnt] = '0;
            m_cnt++;
            if (m_cnt == 32) m_run = 1'b1;
         end else if (wb_en && wb_addr != 0) begin
            m_reg[wb_addr] = wb_data;
         end else if (rd_req) begin
            m_pend = 1'b1;
            m_e1   = (rs1_addr == 0) ? 32'h0 : m_reg[rs1_addr];
            m_e2   = (rs2_addr == 0) ? 32'h0 : m_reg[rs2_addr];
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         automatic bit wb = m_run && wb_en && wb_addr != 0;
         automatic bit ra = m_run && !wb && rd_req;
         chk("rd_ready", rd_ready, m_run && !wb);
         chk("init_done", init_done, m_idone);
         chk("rdata_valid", rdata_valid, m_pend);
         chk("ram_wrea", ram_wrea, !m_run || wb);
         chk("ram_cea", ram_cea, !m_run || wb || ra);
         chk("ram_ceb", ram_ceb, ra);
         if (!m_run) chk("init_ada", ram_ada, m_cnt);
         if (!m_run) chk("init_dina", ram_dina, 0);
         if (wb) chk("wb_ada", ram_ada, wb_addr);
         if (wb) chk("wb_dina", ram_dina, wb_data);
         if (ra) chk("rd_ada", ram_ada, rs1_addr);
         if (ra) chk("rd_adb", ram_adb, rs2_addr);
         chk("rs1_data", rs1_data, m_pend ? m_e1 : m_h1);
         chk("rs2_data", rs2_data, m_pend ? m_e2 : m_h2);
      end
   end

   task automatic cyc(input bit rq, input logic [4:0] a1, input logic [4:0] a2,
                      input bit we, input logic [4:0] wa, input logic [31:0] wd);
      @(posedge clk);
      #1;
      rd_req   = rq;
      rs1_addr = a1;
      rs2_addr = a2;
      wb_en    = we;
      wb_addr  = wa;
      wb_data  = wd;
      @(negedge clk);
      #1;
   endtask

   task automatic idle();
      cyc(0, 0, 0, 0, 0, 0);
   endtask

   task automatic rst_vals(input string nm);
      chk({nm, "_rdy"}, rd_ready, 0);
      chk({nm, "_rv"}, rdata_valid, 0);
      chk({nm, "_rs1"}, rs1_data, 0);
      chk({nm, "_rs2"}, rs2_data, 0);
      chk({nm, "_ce"}, {ram_cea, ram_wrea, ram_ceb}, 0);
      chk({nm, "_ad"}, {ram_ada, ram_adb}, 0);
      chk({nm, "_din"}, ram_dina, 0);
`ifdef REGFILE_CLEAR_EN
      chk({nm, "_done"}, init_done, 0);
`else
      chk({nm, "_done"}, init_done, 1);
`endif
   endtask

   // entered at posedge+1 right after rst_n rises
   task automatic init_seq();
      @(negedge clk);
      #1;
`ifdef REGFILE_CLEAR_EN
      for (int k = 0; k < 32; k++) begin
         if (k > 0) idle();
         chk("T1_wrea", ram_wrea, 1);
         chk("T1_ada", ram_ada, k);
         chk("T1_dina", ram_dina, 0);
         chk("T1_rdy", rd_ready, 0);
      end
      idle();
      chk("T1_rdy_run", rd_ready, 1);
      chk("T1_wrea_run", ram_wrea, 0);
      idle();
      chk("T1_done", init_done, 1);
`else
      chk("rdy_run", rd_ready, 1);
      chk("done", init_done, 1);
`endif
   endtask

   initial begin
      #1 rst_n = 1'b0;
      @(negedge clk);
      #1;
      rst_vals("RST");
      @(posedge clk);
      #1 tb_fill = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      init_seq();

      // T2
      cyc(0, 0, 0, 1, 5, 32'hDEADBEEF);
      chk("T2_wrea", ram_wrea, 1);
      cyc(1, 5, 0, 0, 0, 0);
      chk("T2_rdy", rd_ready, 1);
      idle();
      chk("T2_rv", rdata_valid, 1);
      chk("T2_rs1", rs1_data, 32'hDEADBEEF);
      chk("T2_rs2", rs2_data, 0);

      // T3
      cyc(1, 3, 5, 1, 3, 32'h12345678);
      chk("T3_rdy", rd_ready, 0);
      cyc(1, 3, 5, 0, 0, 0);
      chk("T3_rdy2", rd_ready, 1);
      idle();
      chk("T3_rs1", rs1_data, 32'h12345678);
      chk("T3_rs2", rs2_data, 32'hDEADBEEF);

      // T4
      cyc(1, 0, 3, 1, 0, 32'hFFFFFFFF);
      chk("T4_rdy", rd_ready, 1);
      chk("T4_wrea", ram_wrea, 0);
      idle();
      chk("T4_rs1", rs1_data, 0);
      chk("T4_rs2", rs2_data, 32'h12345678);
      cyc(1, 0, 0, 0, 0, 0);
      idle();
      chk("T4_x0", {rs1_data, rs2_data}, 0);

      // T5: read then write-through traffic on port A
      cyc(0, 0, 0, 1, 7, 32'hA5A5A5A5);
      cyc(1, 7, 5, 0, 0, 0);
      for (int k = 0; k < 3; k++) begin
         cyc(0, 0, 0, 1, 7, 32'h1);
         chk("T5_rs1", rs1_data, 32'hA5A5A5A5);
         chk("T5_rv", rdata_valid, k == 0);
      end
      idle();
      chk("T5_hold", rs2_data, 32'hDEADBEEF);

      // back-to-back reads
      cyc(1, 5, 3, 0, 0, 0);
      cyc(1, 3, 7, 0, 0, 0);
      chk("B2B_rs1a", rs1_data, 32'hDEADBEEF);
      idle();
      chk("B2B_rv", rdata_valid, 1);
      chk("B2B_rs1b", rs1_data, 32'h12345678);
      chk("B2B_rs2b", rs2_data, 32'h1);

      // reset with a read in flight
      cyc(1, 5, 5, 0, 0, 0);
      rst_n = 1'b0;
      #1;
      rst_vals("MRST");
      @(posedge clk);
      @(negedge clk);
      #1;
      rst_vals("MRST2");
      @(posedge clk);
      #1 rst_n = 1'b1;
      init_seq();
      cyc(1, 5, 0, 0, 0, 0);
      idle();
`ifdef REGFILE_CLEAR_EN
      chk("MRST_rd", rs1_data, 0);
`else
      chk("MRST_rd", rs1_data, 32'hDEADBEEF);
`endif

`ifdef REGFILE_CLEAR_EN
      // T6: reset during INIT at count 10
      rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      #1;
      for (int k = 0; k < 10; k++) idle();
      chk("T6_ada", ram_ada, 10);
      rst_n = 1'b0;
      #1;
      rst_vals("T6");
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      init_seq();
`endif

      idle();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
